// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo family: occupancy encoding, read-buffer
// depth and the default word width.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int RD_STREAM_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer that absorbs the FIFO read latency; occupancy is
// kept as a small state machine, storage is addressed by 1-bit wrapping pointers.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occ
);

    occ_e                  state_r;
    occ_e                  state_s;
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [DATA_WIDTH-1:0] mem_r [RD_STREAM_DEPTH];

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Occupancy next-state from push/pop
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (push) state_s = ONE;
                else      state_s = EMPTY;
            end
            ONE: begin
                if (push && !pop)      state_s = TWO;
                else if (!push && pop) state_s = EMPTY;
                else                   state_s = ONE;
            end
            TWO: begin
                if (pop) state_s = ONE;
                else     state_s = TWO;
            end
            default: state_s = EMPTY;
        endcase
    end

    // Occupancy and head word presented to the top level
    always_comb begin
        occ  = state_r;
        head = mem_r[rd_ptr_r];
    end

    // Storage and wrapping pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            for (int i = 0; i < RD_STREAM_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rd_skid_buf_chk.sv
// Simulation checker for rd_skid_buf: a push into a full buffer without a
// simultaneous pop would overwrite the head word.
module rd_skid_buf_chk
    import fifo_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       pop,
    input logic [1:0] occ
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ == TWO)))
        else $error("rd_skid_buf: capture into full buffer without pop");

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for sync_fifo: issues reads, absorbs the read latency
// and streams words out valid/ready. Burst framing via FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    logic       inflight_r;
    logic       pop_s;
    logic [1:0] occ_s;
    logic [2:0] issue_sum_s;

    if ((BURST_LEN < 1) || ((2 ** CNT_WIDTH) < BURST_LEN)) begin : g_bad_cfg
        $error("fifo_rd_stream: BURST_LEN must be >= 1 and fit in CNT_WIDTH bits");
    end

    assign pop_s     = out_valid && out_ready;
    assign out_valid = (occ_s != 2'd0);

    // Words already held or on their way, minus the one leaving this cycle.
    // A pop implies occ >= 1, so the 3-bit sum never underflows.
    assign issue_sum_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign fifo_rd_en  = rst_n && !fifo_empty && (issue_sum_s <= 3'd1);

    // Marks the cycle in which the FIFO read port delivers a word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fifo_rd_en;
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (fifo_rd_data),
        .pop       (pop_s),
        .head      (out_data),
        .occ       (occ_s)
    );

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    logic [CNT_WIDTH-1:0] beat_cnt_r;
    logic                 last_s;

    assign last_s   = out_valid && (beat_cnt_r == LAST_BEAT);
    assign out_last = last_s;

    // Burst beat counter, advanced only by accepted words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (pop_s) begin
            beat_cnt_r <= last_s ? {CNT_WIDTH{1'b0}} : beat_cnt_r + 1'b1;
        end
    end
`else
    assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural FIFO read port
// and a scoreboard of words written into that FIFO.
bind rd_skid_buf rd_skid_buf_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .occ   (occ)
);

module tb_fifo_rd_stream;

    localparam int TB_BURST = 4;
`ifdef FIFO_RD_STREAM_LAST_EN
    localparam bit LAST_ON = 1'b1;
`else
    localparam bit LAST_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;

    logic [7:0] fifo_mem [256];
    int         wr_idx = 0;
    int         rd_idx = 0;
    int         rd_count = 0;
    logic       flush = 1'b0;
    logic [7:0] rd_data_m = 8'h00;

    int         vectors = 0;
    int         miscompares = 0;
    int         pops_total = 0;
    logic [7:0] exp_q [$];

    fifo_rd_stream #(
        .DATA_WIDTH (8),
        .BURST_LEN  (TB_BURST),
        .CNT_WIDTH  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    assign fifo_empty   = (rd_idx == wr_idx);
    assign fifo_rd_data = rd_data_m;

    // Behavioural FIFO read port: registered data, shared reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_m <= 8'h00;
            rd_count  <= 0;
            if (flush) rd_idx <= wr_idx;
        end else if (fifo_rd_en && !fifo_empty) begin
            rd_data_m <= fifo_mem[rd_idx % 256];
            rd_idx    <= rd_idx + 1;
            rd_count  <= rd_count + 1;
        end
    end

    task automatic push_word(input logic [7:0] w);
        fifo_mem[wr_idx % 256] = w;
        exp_q.push_back(w);
        wr_idx = wr_idx + 1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_w;
        bit vexp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bit rexp [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        flush = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        pops_total = 0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", out_data); end
        if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", out_last); end
        if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors += 2;
            if (out_valid !== vexp[i]) begin miscompares++; $display("FAIL reset_latency_valid c%0d: got %b want %b", i, out_valid, vexp[i]); end
            if (fifo_rd_en !== rexp[i]) begin miscompares++; $display("FAIL reset_latency_rd_en c%0d: got %b want %b", i, fifo_rd_en, rexp[i]); end
            if (out_valid && out_ready) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (out_data !== exp_w) begin miscompares++; $display("FAIL reset_data c%0d: got %h want %h", i, out_data, exp_w); end
                pops_total++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_w;
        int got = 0, first = -1, last = -1;
        bit pop_b, rd_exp;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'h40 + 8'(i));
        for (int c = 0; c < 40 && got < 16; c++) begin
            @(negedge clk);
            #1;
            pop_b  = out_valid && out_ready;
            rd_exp = !fifo_empty && ((rd_count - pops_total - (pop_b ? 1 : 0)) <= 1);
            vectors++;
            if (fifo_rd_en !== rd_exp) begin miscompares++; $display("FAIL b2b_rd_en c%0d: got %b want %b", c, fifo_rd_en, rd_exp); end
            if (pop_b) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (out_data !== exp_w) begin miscompares++; $display("FAIL b2b_data c%0d: got %h want %h", c, out_data, exp_w); end
                if (first < 0) first = c;
                last = c;
                got++;
                pops_total++;
            end
        end
        vectors += 2;
        if (got != 16) begin miscompares++; $display("FAIL b2b_count: got %0d want 16", got); end
        if (last - first != 15) begin miscompares++; $display("FAIL b2b_bubble: span %0d want 15", last - first); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_w;
        int got = 0, stall_left = -1, rd_start = 0, rd_end = -1, max_outst = 0, outst;
        bit pop_b, rd_exp;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_word(8'h80 + 8'(i));
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            if (got == 3 && stall_left < 0) begin stall_left = 5; rd_start = rd_count; end
            if (stall_left == 0 && rd_end < 0) rd_end = rd_count;
            out_ready = !(stall_left > 0);
            #1;
            pop_b  = out_valid && out_ready;
            outst  = rd_count - pops_total;
            if (outst > max_outst) max_outst = outst;
            rd_exp = !fifo_empty && ((outst - (pop_b ? 1 : 0)) <= 1);
            vectors++;
            if (fifo_rd_en !== rd_exp) begin miscompares++; $display("FAIL bp_rd_en c%0d: got %b want %b", c, fifo_rd_en, rd_exp); end
            if (stall_left > 0 && out_valid && exp_q.size() > 0) begin
                vectors++;
                if (out_data !== exp_q[0]) begin miscompares++; $display("FAIL bp_hold c%0d: got %h want %h", c, out_data, exp_q[0]); end
            end
            if (pop_b) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (out_data !== exp_w) begin miscompares++; $display("FAIL bp_data c%0d: got %h want %h", c, out_data, exp_w); end
                got++;
                pops_total++;
            end
            if (stall_left > 0) stall_left--;
        end
        vectors += 3;
        if (got != 10) begin miscompares++; $display("FAIL bp_count: got %0d want 10", got); end
        if (max_outst != 2) begin miscompares++; $display("FAIL bp_occ: peak %0d want 2", max_outst); end
        if (rd_end < 0 || rd_end - rd_start > 1) begin miscompares++; $display("FAIL bp_extra_reads: got %0d want <=1", rd_end - rd_start); end
    endtask

    task automatic test_toggle();
        logic [7:0] exp_w;
        int got = 0;
        bit pop_b, rd_exp;
        @(negedge clk);
        for (int i = 0; i < 10; i++) push_word(8'hC0 + 8'(i));
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            out_ready = (c % 2 == 0);
            #1;
            pop_b  = out_valid && out_ready;
            rd_exp = !fifo_empty && ((rd_count - pops_total - (pop_b ? 1 : 0)) <= 1);
            vectors++;
            if (fifo_rd_en !== rd_exp) begin miscompares++; $display("FAIL toggle_rd_en c%0d: got %b want %b", c, fifo_rd_en, rd_exp); end
            if (pop_b) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (out_data !== exp_w) begin miscompares++; $display("FAIL toggle_data c%0d: got %h want %h", c, out_data, exp_w); end
                got++;
                pops_total++;
            end
        end
        vectors++;
        if (got != 10) begin miscompares++; $display("FAIL toggle_count: got %0d want 10", got); end
    endtask

    task automatic test_last();
        logic [7:0] exp_w;
        int got = 0, lasts = 0, stall_left = -1;
        bit pop_b, last_exp;
        flush = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        pops_total = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) push_word(8'hD0 + 8'(i));
        for (int c = 0; c < 60 && got < 12; c++) begin
            @(negedge clk);
            if (pops_total == 3 && out_valid && stall_left < 0) stall_left = 3;
            out_ready = !(stall_left > 0);
            #1;
            pop_b    = out_valid && out_ready;
            last_exp = LAST_ON && ((pops_total % TB_BURST) == TB_BURST - 1);
            if (out_valid) begin
                vectors++;
                if (out_last !== last_exp) begin miscompares++; $display("FAIL last_flag word%0d: got %b want %b", pops_total + 1, out_last, last_exp); end
            end
            if (pop_b) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (out_data !== exp_w) begin miscompares++; $display("FAIL last_data c%0d: got %h want %h", c, out_data, exp_w); end
                if (out_last) lasts++;
                got++;
                pops_total++;
            end
            if (stall_left > 0) stall_left--;
        end
        vectors += 2;
        if (got != 12) begin miscompares++; $display("FAIL last_count: got %0d want 12", got); end
        if (lasts != (LAST_ON ? 3 : 0)) begin miscompares++; $display("FAIL last_total: got %0d want %0d", lasts, LAST_ON ? 3 : 0); end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] exp_w;
        int got = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'hE0 + 8'(i));
        repeat (6) @(negedge clk);
        #1;
        vectors += 2;
        if (rd_count - pops_total != 2) begin miscompares++; $display("FAIL mid_fill: got %0d want 2", rd_count - pops_total); end
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid: got %b want 1", out_valid); end
        #1;
        flush = 1'b1;
        rst_n = 1'b0;
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_data: got %h want 00", out_data); end
        if (out_last !== 1'b0) begin miscompares++; $display("FAIL mid_rst_last: got %b want 0", out_last); end
        if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rd_en: got %b want 0", fifo_rd_en); end
        repeat (2) @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        pops_total = 0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_idle c%0d: got %b want 0", c, out_valid); end
        end
        @(negedge clk);
        push_word(8'hA1);
        push_word(8'hA2);
        for (int c = 0; c < 10 && got < 2; c++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                vectors++;
                if (out_data !== exp_w) begin miscompares++; $display("FAIL mid_data c%0d: got %h want %h", c, out_data, exp_w); end
                got++;
                pops_total++;
            end
        end
        vectors++;
        if (got != 2) begin miscompares++; $display("FAIL mid_count: got %0d want 2", got); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_last();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
